// File: rtl/pipe_pkg.sv
// Shared definitions for the parametrised pipeline stage register: occupancy
// encodings, default payload width and the NOP payload used on IF/ID flush.
package pipe_pkg;

    typedef logic [1:0] occ_t;

    localparam occ_t OCC_EMPTY = 2'd0;
    localparam occ_t OCC_ONE   = 2'd1;
    localparam occ_t OCC_FULL  = 2'd2;

    localparam int unsigned DATA_W_DEF = 64;

    // RV32I canonical NOP (addi x0, x0, 0) in the instruction half, PC half zero.
    localparam logic [31:0]            RV_NOP         = 32'h0000_0013;
    localparam logic [DATA_W_DEF-1:0]  IFID_FLUSH_VAL = {32'h0000_0000, RV_NOP};

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage with a two-entry skid buffer (registered in_ready),
// freeze/flush controls and saturating stall/flush event counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W    = DATA_W_DEF,
    parameter logic [DATA_W-1:0] RST_VAL   = '0,
    parameter logic [DATA_W-1:0] FLUSH_VAL = '0,
    parameter int unsigned       CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic              r_main_v, r_skid_v, r_in_ready_q;
    logic [DATA_W-1:0] r_main_d, r_skid_d;

    logic              w_main_v_d, w_skid_v_d;
    logic [DATA_W-1:0] w_main_d_d, w_skid_d_d;
    logic              w_acc, w_pop, w_stall_inc;
    occ_t              w_occ;

    assign in_ready  = r_in_ready_q & ~freeze;
    assign out_valid = r_main_v & ~freeze;
    assign out_data  = r_main_d;

    assign w_acc = in_valid & in_ready;
    assign w_pop = out_valid & out_ready;
    assign w_occ = !r_main_v ? OCC_EMPTY : (r_skid_v ? OCC_FULL : OCC_ONE);

    always_comb begin
        w_main_v_d = r_main_v;
        w_skid_v_d = r_skid_v;
        w_main_d_d = r_main_d;
        w_skid_d_d = r_skid_d;
        if (flush) begin
            w_main_v_d = 1'b0;
            w_skid_v_d = 1'b0;
            w_main_d_d = FLUSH_VAL;
            w_skid_d_d = FLUSH_VAL;
        end else if (!freeze) begin
            unique case (w_occ)
                OCC_EMPTY: begin
                    if (w_acc) begin
                        w_main_v_d = 1'b1;
                        w_main_d_d = in_data;
                    end
                end
                OCC_ONE: begin
                    if (w_acc && w_pop) begin
                        w_main_d_d = in_data;
                    end else if (w_acc) begin
                        w_skid_v_d = 1'b1;
                        w_skid_d_d = in_data;
                    end else if (w_pop) begin
                        w_main_v_d = 1'b0;
                    end
                end
                OCC_FULL: begin
                    // in_ready is low here, so only a pop can occur
                    if (w_pop) begin
                        w_main_d_d = r_skid_d;
                        w_skid_v_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_v     <= 1'b0;
            r_skid_v     <= 1'b0;
            r_main_d     <= RST_VAL;
            r_skid_d     <= RST_VAL;
            r_in_ready_q <= 1'b1;
        end else begin
            r_main_v     <= w_main_v_d;
            r_skid_v     <= w_skid_v_d;
            r_main_d     <= w_main_d_d;
            r_skid_d     <= w_skid_d_d;
            r_in_ready_q <= ~w_skid_v_d;
        end
    end

    assign w_stall_inc = !flush && (freeze || (out_valid && !out_ready));

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_stall_inc),
        .clear (1'b0),
        .cnt   (stall_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush),
        .clear (1'b0),
        .cnt   (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a 16-bit-counter instance and a 4-bit-counter
// instance share all inputs; expected values are hand-computed per step.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int unsigned    DW  = 64;
    localparam logic [DW-1:0]  NOP = IFID_FLUSH_VAL;

    logic          clk = 1'b0;
    logic          rst, freeze, flush, in_valid, out_ready;
    logic [DW-1:0] in_data;

    logic          a_in_ready, a_out_valid;
    logic [DW-1:0] a_out_data;
    logic [15:0]   a_stall, a_flush;
    logic          b_in_ready, b_out_valid;
    logic [DW-1:0] b_out_data;
    logic [3:0]    b_stall, b_flush;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .DATA_W    (DW),
        .RST_VAL   ('0),
        .FLUSH_VAL (NOP),
        .CNT_W     (16)
    ) dut_a (
        .clk       (clk),
        .rst       (rst),
        .freeze    (freeze),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (a_in_ready),
        .out_valid (a_out_valid),
        .out_data  (a_out_data),
        .out_ready (out_ready),
        .stall_cnt (a_stall),
        .flush_cnt (a_flush)
    );

    pipe_stage_reg #(
        .DATA_W    (DW),
        .RST_VAL   ('0),
        .FLUSH_VAL (NOP),
        .CNT_W     (4)
    ) dut_b (
        .clk       (clk),
        .rst       (rst),
        .freeze    (freeze),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (b_in_ready),
        .out_valid (b_out_valid),
        .out_data  (b_out_data),
        .out_ready (out_ready),
        .stall_cnt (b_stall),
        .flush_cnt (b_flush)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        chk("skid_without_main", {63'd0, dut_a.r_skid_v & ~dut_a.r_main_v}, 64'd0);
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0; flush = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", {63'd0, a_out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, a_in_ready}, 64'd1);
        chk("rst_out_data", a_out_data, 64'd0);

        // Fill to FULL under backpressure, then reset asynchronously mid-stream
        in_valid = 1'b1; in_data = 64'h55;
        tick(); tick(); tick();
        chk("pre_rst_stall", a_stall, 64'd2);
        chk("pre_rst_in_ready", {63'd0, a_in_ready}, 64'd0);
        chk("pre_rst_out_valid", {63'd0, a_out_valid}, 64'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", {63'd0, a_out_valid}, 64'd0);
        chk("async_rst_out_data", a_out_data, 64'd0);
        chk("async_rst_in_ready", {63'd0, a_in_ready}, 64'd1);
        chk("async_rst_stall", a_stall, 64'd0);
        chk("async_rst_flush", a_flush, 64'd0);
        in_valid = 1'b0;
        tick();
        rst = 1'b0;

        // Streaming with one-cycle latency
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = 64'(i);
            tick();
            chk("stream_valid", {63'd0, a_out_valid}, 64'd1);
            chk("stream_data", a_out_data, 64'(i));
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drained", {63'd0, a_out_valid}, 64'd0);
        chk("stream_stall", a_stall, 64'd0);

        // Backpressure into FULL, then drain in order
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 64'hA;
        tick();
        chk("bp_ready_one", {63'd0, a_in_ready}, 64'd1);
        chk("bp_data_a", a_out_data, 64'hA);
        in_data = 64'hB;
        tick();
        chk("bp_ready_full", {63'd0, a_in_ready}, 64'd0);
        chk("bp_full_state", {62'd0, dut_a.r_skid_v, dut_a.r_main_v}, 64'd3);
        chk("bp_stall1", a_stall, 64'd1);
        tick();
        chk("bp_stall2", a_stall, 64'd2);
        chk("bp_hold_a", a_out_data, 64'hA);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("bp_pop_b", a_out_data, 64'hB);
        chk("bp_ready_back", {63'd0, a_in_ready}, 64'd1);
        chk("bp_stall_hold", a_stall, 64'd2);
        tick();
        chk("bp_empty", {63'd0, a_out_valid}, 64'd0);

        // Flush while FULL with input offered
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 64'h11;
        tick();
        in_data = 64'h12;
        tick();
        flush = 1'b1; in_data = 64'hC;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_out_valid", {63'd0, a_out_valid}, 64'd0);
        chk("fl_out_data", a_out_data, NOP);
        chk("fl_cnt", a_flush, 64'd1);
        chk("fl_stall", a_stall, 64'd3);
        out_ready = 1'b1;
        tick();
        chk("fl_no_c", {63'd0, a_out_valid}, 64'd0);

        // Freeze for three cycles while holding 0xD
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 64'hD;
        tick();
        in_data = 64'hE; freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("fz_in_ready", {63'd0, a_in_ready}, 64'd0);
            chk("fz_out_valid", {63'd0, a_out_valid}, 64'd0);
            chk("fz_out_data", a_out_data, 64'hD);
            tick();
        end
        chk("fz_stall", a_stall, 64'd6);
        freeze = 1'b0; out_ready = 1'b1;
        #1;
        chk("fz_rel_out_valid", {63'd0, a_out_valid}, 64'd1);
        chk("fz_rel_in_ready", {63'd0, a_in_ready}, 64'd1);
        tick();
        chk("fz_next_data", a_out_data, 64'hE);
        chk("fz_stall_after", a_stall, 64'd6);
        in_valid = 1'b0;
        tick();

        // Flush and freeze together: flush wins, no stall counted
        in_valid = 1'b1; in_data = 64'h21;
        tick();
        in_valid = 1'b0; flush = 1'b1; freeze = 1'b1;
        tick();
        flush = 1'b0; freeze = 1'b0;
        chk("ff_out_valid", {63'd0, a_out_valid}, 64'd0);
        chk("ff_out_data", a_out_data, NOP);
        chk("ff_flush_cnt", a_flush, 64'd2);
        chk("ff_stall_cnt", a_stall, 64'd6);
        chk("ff_b_stall", b_stall, 64'd6);

        // Saturation of the 4-bit stall counter
        rst = 1'b1;
        #1;
        chk("sat_rst_b", b_stall, 64'd0);
        rst = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 64'h31;
        tick();
        in_valid = 1'b0;
        repeat (14) tick();
        chk("sat_b_14", b_stall, 64'hE);
        chk("sat_a_14", a_stall, 64'd14);
        tick();
        chk("sat_b_15", b_stall, 64'hF);
        repeat (5) tick();
        chk("sat_b_20", b_stall, 64'hF);
        chk("sat_a_20", a_stall, 64'd20);
        chk("sat_b_data", b_out_data, 64'h31);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register that succeeds the fixed 32-bit IF/ID-style stage registers.
- Carries a DATA_W-bit payload between two pipeline stages using a valid/ready handshake.
- Has a two-entry skid buffer, so in_ready is driven from a register.
- Keeps freeze (stall) and flush (bubble insert) controls, and adds saturating stall and flush event counters for performance debug.

Parameters:
- DATA_W, 64, payload width in bits (e.g. PC concatenated with Instruction).
- RST_VAL, 0, payload value after reset (DATA_W bits, zero-extended).
- FLUSH_VAL, 0, payload value written on flush (a NOP encoding may be supplied).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- freeze  in  1  hold the stage; no transfer on either side.
- flush  in  1  discard all held entries.
- in_valid  in  1  upstream payload valid.
- in_data  in  DATA_W  upstream payload.
- in_ready  out  1  stage can accept.
- out_valid  out  1  downstream payload valid.
- out_data  out  DATA_W  downstream payload.
- out_ready  in  1  downstream accepts.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.
- flush_cnt  out  CNT_W  saturating count of flush cycles.

Behaviour:
- Reset: one clock, async active-high.
  - Asserting rst immediately clears main_v and skid_v and loads RST_VAL into main_d and skid_d.
  - Asserting rst zeroes both counters and sets in_ready_q=1.
  - This applies mid-transfer too; any in-flight data is dropped.
- Storage: main (main_v, main_d) drives out_data; skid (skid_v, skid_d) holds overflow.
- Occupancy states:
  - EMPTY: main_v=0.
  - ONE: main_v=1, skid_v=0.
  - FULL: main_v=1, skid_v=1.
  - skid_v=1 with main_v=0 is illegal; the bench asserts it never occurs.
- Handshake outputs:
  - in_ready = in_ready_q & ~freeze, where in_ready_q = ~skid_v is registered.
  - out_valid = main_v & ~freeze.
  - out_data = main_d at all times, including during freeze.
- Transfer definitions: acc = in_valid & in_ready; pop = out_valid & out_ready.
- Priority per cycle is rst > flush > freeze > normal.
- flush:
  - Next state is EMPTY; main_d and skid_d load FLUSH_VAL.
  - Any input offered in the same cycle is discarded, even if in_ready was high.
  - flush_cnt increments by 1 (saturating).
  - freeze is ignored in a flush cycle.
- freeze (no flush):
  - Entries, data and in_ready_q are unchanged.
  - stall_cnt increments (saturating).
- Normal transitions (latency is one cycle, in_data to out_data, from EMPTY or ONE with pop):
  - EMPTY + acc -> ONE; main_d <= in_data.
  - ONE + acc + pop -> ONE; main_d <= in_data.
  - ONE + acc, no pop -> FULL; skid_d <= in_data.
  - ONE + pop, no acc -> EMPTY.
  - FULL + pop -> ONE; main_d <= skid_d. acc is impossible because in_ready=0.
  - No acc and no pop: hold.
- stall_cnt also increments on any non-freeze, non-flush cycle with out_valid=1 and out_ready=0.
- Counter saturation: both counters hold at all-ones; they do not wrap.
- Data ordering: entries leave in acceptance order; no duplication and no loss except via flush or rst.

Decomposition:
- Shared package pipe_pkg: occupancy encoding constants (OCC_EMPTY=2'd0, OCC_ONE=2'd1, OCC_FULL=2'd2), default DATA_W, and the NOP encoding constant used as FLUSH_VAL by the IF/ID instance.
- One sub-module: sat_counter (CNT_W, inc, clear; async active-high rst). It is instantiated twice.

Test Plan:
- Reset and streaming: assert rst mid-stream with DATA_W=64 -> out_valid=0, out_data=0, in_ready=1, counters=0 at once. Then stream 0x1..0x8 with out_ready=1 -> the same values appear one cycle later, back-to-back, in order.
- Backpressure: send 0xA then 0xB, hold out_ready=0 -> in_ready drops after the second accept, state is FULL, and stall_cnt increments each cycle. Raise out_ready -> 0xA then 0xB emerge in order with no loss.
- Flush while full: flush=1 with in_valid=1 and in_data=0xC -> next cycle out_valid=0, out_data=FLUSH_VAL, 0xC is never emitted, flush_cnt=1.
- Freeze: freeze=1 for 3 cycles while in ONE holding 0xD, in_valid=1 -> in_ready=0 and out_valid=0 throughout; out_data=0xD; stall_cnt+=3. After release, 0xD pops and the input is accepted.
- Flush+freeze simultaneous -> flush wins: state EMPTY, flush_cnt+1, stall_cnt unchanged.
- Saturation with CNT_W=4: hold out_ready=0 for 20 cycles -> stall_cnt sticks at 4'hF.
